// File: rtl/float_minmax_reduce.sv
// float_minmax_reduce
// Streaming IEEE 754-2008 minNum/maxNum reduction. Elements arrive over a
// valid/ready handshake; once the element flagged in_last has been accepted,
// the minimum or maximum of the vector is presented until the consumer
// accepts it.
//
// Optional feature macro: FPU_MINMAX_IDX_EN
//   defined   -> out_idx port, index register and element counter are built
//   undefined -> no index tracking; value, handshake and flags are unchanged
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   in_valid     element valid
//   in_ready     unit can accept an element (0 in DONE and while RST is high)
//   in_data      element value
//   in_last      element is the last of the vector
//   in_max       1 = maximum, 0 = minimum; sampled on the first element only
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     reduced value (canonical NaN if every element was NaN)
//   out_idx      index of the winning element (FPU_MINMAX_IDX_EN only)
//   out_invalid  at least one signalling NaN was seen in the vector
module float_minmax_reduce #(
    parameter int FLOAT_WIDTH    = 16,
    parameter int EXPONENT_WIDTH = 5,
    parameter int FRACTION_WIDTH = 10,
    parameter int IDX_W          = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    input  logic                   in_last,
    input  logic                   in_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out_data,
`ifdef FPU_MINMAX_IDX_EN
    output logic [IDX_W-1:0]       out_idx,
`endif
    output logic                   out_invalid
);

    if (FLOAT_WIDTH != 1 + EXPONENT_WIDTH + FRACTION_WIDTH || IDX_W < 1) begin : g_bad_params
        $error("float_minmax_reduce: inconsistent float field widths or IDX_W");
    end

    localparam logic [FLOAT_WIDTH-1:0] CANON_NAN =
        {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state_q, state_nxt;

    function automatic logic f_is_nan(input logic [FLOAT_WIDTH-1:0] v);
        return (&v[FLOAT_WIDTH-2 -: EXPONENT_WIDTH]) && (|v[FRACTION_WIDTH-1:0]);
    endfunction

    function automatic logic f_is_snan(input logic [FLOAT_WIDTH-1:0] v);
        return f_is_nan(v) && !v[FRACTION_WIDTH-1];
    endfunction

    // Map a non-NaN float onto an unsigned key whose natural order is the
    // float total order: negatives are bit-inverted, positives get the MSB
    // set, so -0 (key 0x7FFF for half) sits just below +0 (key 0x8000).
    function automatic logic [FLOAT_WIDTH-1:0] f_order_key(input logic [FLOAT_WIDTH-1:0] v);
        return v[FLOAT_WIDTH-1] ? ~v : {1'b1, v[FLOAT_WIDTH-2:0]};
    endfunction

    function automatic logic [FLOAT_WIDTH-1:0] f_canon(input logic [FLOAT_WIDTH-1:0] v);
        return f_is_nan(v) ? CANON_NAN : v;
    endfunction

    logic [FLOAT_WIDTH-1:0] acc_p0;
    logic                   max_p0;
    logic                   invalid_p0;
    logic [FLOAT_WIDTH-1:0] out_data_p1;

    logic                   accept;
    logic                   first;
    logic                   mode;
    logic                   cand_nan;
    logic                   acc_nan;
    logic                   better;
    logic                   take;
    logic [FLOAT_WIDTH-1:0] acc_nxt;
    logic                   invalid_nxt;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_nxt = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !RST;
                if (in_valid && !RST) state_nxt = in_last ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = !RST;
                if (in_valid && !RST && in_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Comparator: single-cycle, accumulator register against in_data
    always_comb begin
        accept   = in_valid && in_ready;
        first    = (state_q == IDLE);
        mode     = first ? in_max : max_p0;
        cand_nan = f_is_nan(in_data);
        acc_nan  = f_is_nan(acc_p0);
        better   = mode ? (f_order_key(in_data) > f_order_key(acc_p0))
                        : (f_order_key(in_data) < f_order_key(acc_p0));
        // Ties keep the accumulator so the earliest element wins.
        take        = first || (!cand_nan && (acc_nan || better));
        acc_nxt     = take ? in_data : acc_p0;
        invalid_nxt = (!first && invalid_p0) || f_is_snan(in_data);
    end

    // Stage p0: accumulator and per-vector flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            max_p0     <= 1'b0;
            invalid_p0 <= 1'b0;
        end else if (accept) begin
            max_p0     <= mode;
            invalid_p0 <= invalid_nxt;
        end
        if (accept) acc_p0 <= acc_nxt;
    end

    // Stage p1: registered result, loaded on the last-element handshake
    always_ff @(posedge CLK) begin
        if (RST)                    out_data_p1 <= '0;
        else if (accept && in_last) out_data_p1 <= f_canon(acc_nxt);
    end

    assign out_data    = out_data_p1;
    assign out_invalid = invalid_p0;

`ifdef FPU_MINMAX_IDX_EN
    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0] count_p0;
    logic [IDX_W-1:0] idx_p0;

    // Stage p0: element counter (saturating) and winning index
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_p0 <= '0;
            idx_p0   <= '0;
        end else if (accept) begin
            if (first) begin
                count_p0 <= IDX_W'(1);
                idx_p0   <= '0;
            end else begin
                if (count_p0 != CNT_MAX) count_p0 <= count_p0 + IDX_W'(1);
                if (take)                idx_p0   <= count_p0;
            end
        end
    end

    assign out_idx = idx_p0;
`endif

endmodule

// File: doc/float_minmax_reduce.md
# float_minmax_reduce

Streaming min/max reduction unit for the FPU vector path: it consumes a sequence of floats over a valid/ready handshake and returns the minimum or maximum of the sequence, with the index of the winning element. It is width-parametrised (half and single precision). It follows IEEE 754-2008 minNum/maxNum semantics:
- any NaN encoding is recognised;
- -0 orders below +0;
- signalling NaNs are flagged.

It sits between the vector operand buffer and the FPU result writeback.

## Interface
Parameters:
- FLOAT_WIDTH, 16, total float width
- EXPONENT_WIDTH, 5, exponent field width
- FRACTION_WIDTH, 10, fraction field width
- IDX_W, 8, width of the element index/counter

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- in_valid  input  1  element valid
- in_ready  output  1  unit can accept an element
- in_data  input  FLOAT_WIDTH  element value
- in_last  input  1  element is the last of the vector
- in_max  input  1  1 = maximum, 0 = minimum; sampled on the first element of a vector only
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  FLOAT_WIDTH  reduced value
- out_idx  output  IDX_W  index of the winning element (present only with FPU_MINMAX_IDX_EN)
- out_invalid  output  1  at least one sNaN was seen in the vector

## Operation
- **Classification**
  - NaN: exponent all ones, fraction ≠ 0.
  - sNaN: NaN with fraction MSB = 0.
  - Canonical NaN: sign 0, exponent all ones, fraction MSB 1, remaining fraction bits 0 (0x7E00 for half precision).
- **Ordering:** total order on non-NaN values, with -inf < negatives < -0 < +0 < positives < +inf.
- **States**
  - IDLE: in_ready = 1. An accepted element loads the accumulator, latches in_max, sets idx = 0 and count = 1. If in_last is also set, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready = 1. Each accepted element is compared with the accumulator:
    - The candidate replaces the accumulator if it is strictly better (greater for max, smaller for min).
    - If the accumulator is NaN and the candidate is not NaN, the candidate replaces the accumulator.
    - If the candidate is NaN, the accumulator is kept.
    - On a tie, the accumulator is kept, so the earliest index wins.
    - On replacement, idx := count.
    - count increments on every accepted element.
    - Accepting an element with in_last set moves to DONE.
  - DONE: in_ready = 0, out_valid = 1.
    - If the accumulator is NaN, out_data is the canonical NaN; otherwise it is the accumulator.
    - On out_ready, go to IDLE.
- **out_invalid:** OR over all accepted elements of the vector that are sNaN. Cleared when a new vector starts.
- **Counter:** count saturates at 2^IDX_W-1. Elements at or beyond that position report idx = 2^IDX_W-1.
- **Back-pressure and idle inputs:** in_valid low in any state → no change. in_max is ignored after the first element.
- **Outputs:** out_data, out_idx and out_invalid are registered and held stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset state (RST high at a rising edge): state IDLE, out_valid 0, out_data 0, out_idx 0, out_invalid 0, count 0.
- in_ready is forced 0 during any cycle in which RST is high.
- RST asserted mid-vector or in DONE: the partial result is discarded and no out_valid is issued.
- Throughput: one element per cycle in IDLE/ACCUM.
- Latency: out_valid rises in the cycle after the in_last element handshake.
- One-cycle bubble: DONE holds in_ready = 0, so the next vector's first element is accepted no earlier than the cycle after the out handshake.
- Single-element vector (in_last on the first element): result in the next cycle, idx 0.
- The comparator is single-cycle combinational between the accumulator register and in_data.

## Configuration
- FPU_MINMAX_IDX_EN defined:
  - out_idx port exists.
  - The idx register and the comparison-position logic are built.
  - The counter is IDX_W wide.
- FPU_MINMAX_IDX_EN undefined:
  - out_idx port, idx register and counter are removed.
  - Value, handshake and flag behaviour are identical.

## Test plan
- Max of {0x3C00, 0xC000, 0x4000(last)} → out_data 0x4000, out_idx 2, out_invalid 0, out_valid one cycle after last.
- Min of {0x0000, 0x8000(last)} → out_data 0x8000, idx 1. Max of the same vector → 0x0000, idx 0.
- Max of {0x7E00, 0xFC00, 0x7C01(last)} → out_data 0xFC00, idx 1, out_invalid 1.
- Min of {0x7C01, 0xFE00(last)} → out_data 0x7E00, idx 0, out_invalid 1.
- Max vector ending {…, 0x4000 at idx 3, 0x4000 at idx 5}: hold out_ready low 4 cycles → outputs stable, in_ready 0, idx 3. Release → back to IDLE, next vector accepted the following cycle.
- RST pulse after 2 elements of a vector → no out_valid. A fresh single-element vector 0x3C00 then yields 0x3C00, idx 0.
